program_memory_loader: RTL
==========================

Name: program_memory_loader

Overview:
- Write-side counterpart of the program memory: fills a writable program memory with instructions streamed in as bytes.
- Packs bytes little-endian into DATA_WIDTH words and issues one write strobe per word, at sequential word addresses starting from 0.
- Sits between a byte source (UART or bench) and the write port of the program memory. The fetch side reads that memory after done_o.

Parameters:
- MEMORY_DEPTH, 32, number of words in the program memory; the loader never writes above address MEMORY_DEPTH-1.
- DATA_WIDTH, 32, word and address width. Must be a multiple of 8. BYTES = DATA_WIDTH/8.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start_i  input  1  one-cycle pulse that begins a load at address 0.
- byte_i  input  8  incoming program byte.
- byte_valid_i  input  1  byte_i is valid this cycle.
- last_i  input  1  qualified by byte_valid_i; marks the final byte of the program.
- byte_ready_o  output  1  loader accepts a byte this cycle.
- mem_write_o  output  1  write strobe to the program memory, one cycle per word.
- mem_address_o  output  DATA_WIDTH  word address of the current write.
- mem_data_o  output  DATA_WIDTH  assembled word.
- word_count_o  output  DATA_WIDTH  number of words written in the current or last load.
- busy_o  output  1  state is COLLECT or WRITE.
- done_o  output  1  load complete; held high.

Behaviour:
- Reset is asynchronous and active-high. It forces state IDLE and clears every output and internal register to 0: ready, write, address, data, count, busy, done, byte lane counter, last flag.
- A byte is accepted only when byte_valid_i=1 and byte_ready_o=1 on the same rising edge.
- FSM states: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - byte_ready_o=0.
  - start_i=1 → COLLECT. On entry, clear lane counter, word address, word_count_o, the assembly register and the last flag.
- COLLECT:
  - byte_ready_o=1, busy_o=1.
  - Each accepted byte goes to bits [8k+7:8k], where k is the lane counter; k then increments.
  - Go to WRITE when the accepted byte fills lane BYTES-1, or when it carries last_i=1.
  - On last_i, lanes that are not filled are zero.
- WRITE (exactly one cycle):
  - mem_write_o=1, mem_address_o=current word address, mem_data_o=assembled word, byte_ready_o=0.
  - On exit: word_count_o increments and the assembly register and lane counter clear.
  - Go to DONE if the last flag is set or the address is MEMORY_DEPTH-1. Otherwise the address increments and the state returns to COLLECT.
- DONE:
  - done_o=1, busy_o=0, byte_ready_o=0. Any later bytes stall at the source; they are not dropped silently.
  - start_i=1 → COLLECT, with done_o cleared and all counters reset.
- Latency: mem_write_o asserts on the cycle after the edge that accepted the word-completing byte.
- mem_address_o and mem_data_o hold their last values outside WRITE. Only mem_write_o qualifies them.
- start_i is ignored in COLLECT and WRITE.
- byte_valid_i is ignored outside COLLECT.
- last_i is ignored when byte_valid_i=0.
- Memory full: the word at MEMORY_DEPTH-1 completes the load, even without last_i.
- last_i on lane 0 writes one word with bits [DATA_WIDTH-1:8] = 0.
- Reset during COLLECT or WRITE aborts the load immediately: mem_write_o drops asynchronously and the partial word is discarded.

Test Plan:
- Reset: assert reset mid-cycle → all outputs 0 at once, with no clock edge needed.
- Basic load:
  - Stimulus: start_i, then bytes 0x13,0x00,0x00,0x00, then 0x93,0x00,0x10,0x00 with last_i on the final byte.
  - Required: writes addr 0 = 0x00000013 and addr 1 = 0x00100093; word_count_o=2; done_o=1; byte_ready_o=0.
- Partial final word: bytes 0xAA,0xBB,0xCC with last_i on 0xCC → single write addr 0 = 0x00CCBBAA, word_count_o=1.
- Backpressure and gaps:
  - Stimulus: byte_valid_i toggled randomly; a byte presented during WRITE.
  - Required: that byte is held and accepted the next cycle, and no bytes are lost or duplicated.
- Full memory: MEMORY_DEPTH=4, 20 bytes, no last_i → 4 writes at addresses 0..3, done_o=1, byte_ready_o=0 with 4 bytes still pending.
- Restart and abort:
  - start_i in DONE → address restarts at 0, word_count_o=0.
  - reset after 2 bytes → no mem_write_o pulse.
  - start_i during COLLECT → ignored.

Source files
------------

// File: rtl/program_memory_loader_if.sv
// Byte-stream and program-memory write bus of the program memory loader.
// Handshake: a byte moves on a rising edge where byte_valid_i and byte_ready_o
// are both 1; the source must hold byte_i/last_i stable until that edge, and
// last_i means nothing while byte_valid_i is 0. mem_write_o alone qualifies
// mem_address_o/mem_data_o.
interface program_memory_loader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start_i;
    logic [7:0]            byte_i;
    logic                  byte_valid_i;
    logic                  last_i;
    logic                  byte_ready_o;
    logic                  mem_write_o;
    logic [DATA_WIDTH-1:0] mem_address_o;
    logic [DATA_WIDTH-1:0] mem_data_o;
    logic [DATA_WIDTH-1:0] word_count_o;
    logic                  busy_o;
    logic                  done_o;

    // Byte source / controller side.
    modport master (
        output start_i, byte_i, byte_valid_i, last_i,
        input  byte_ready_o, mem_write_o, mem_address_o, mem_data_o,
               word_count_o, busy_o, done_o
    );

    // Loader side.
    modport slave (
        input  start_i, byte_i, byte_valid_i, last_i,
        output byte_ready_o, mem_write_o, mem_address_o, mem_data_o,
               word_count_o, busy_o, done_o
    );
endinterface

// File: rtl/program_memory_loader.sv
// Program memory loader: packs a byte stream little-endian into DATA_WIDTH
// words and writes them to sequential word addresses starting at 0.
// All outputs are registered; state_o exposes the FSM state for debug.
module program_memory_loader #(
    parameter int MEMORY_DEPTH = 32,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    program_memory_loader_if.slave bus,
    output logic [1:0]            state_o
);
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(BYTES - 1);
    localparam logic [DATA_WIDTH-1:0] LAST_ADDR = DATA_WIDTH'(MEMORY_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [LANE_W-1:0]     lane_q, lane_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic                  last_q, last_d;
    logic                  ready_q, ready_d;
    logic                  write_q, write_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  accept;

    // Next-state and next-output computation; outputs follow the next state so
    // they are registered yet always consistent with state_q.
    always_comb begin
        state_d       = state_q;
        lane_d        = lane_q;
        asm_d         = asm_q;
        addr_d        = addr_q;
        count_d       = count_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        last_d        = last_q;
        accept        = bus.byte_valid_i && ready_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start_i) begin
                    state_d = COLLECT;
                    lane_d  = '0;
                    addr_d  = '0;
                    count_d = '0;
                    asm_d   = '0;
                    last_d  = 1'b0;
                end
            end
            COLLECT: begin
                if (accept) begin
                    for (int k = 0; k < BYTES; k++) begin
                        if (lane_q == LANE_W'(k)) begin
                            asm_d[8*k +: 8] = bus.byte_i;
                        end
                    end
                    lane_d = lane_q + LANE_W'(1);
                    // Unfilled upper lanes are still zero from the last clear.
                    if (lane_q == LAST_LANE || bus.last_i) begin
                        state_d       = WRITE;
                        last_d        = bus.last_i;
                        mem_address_d = addr_q;
                        mem_data_d    = asm_d;
                    end
                end
            end
            WRITE: begin
                count_d = count_q + DATA_WIDTH'(1);
                asm_d   = '0;
                lane_d  = '0;
                if (last_q || addr_q == LAST_ADDR) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + DATA_WIDTH'(1);
                    state_d = COLLECT;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == COLLECT);
        write_d = (state_d == WRITE);
        busy_d  = (state_d == COLLECT) || (state_d == WRITE);
        done_d  = (state_d == DONE);
    end

    // State and output registers; reset aborts any load at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            lane_q        <= '0;
            asm_q         <= '0;
            addr_q        <= '0;
            count_q       <= '0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            last_q        <= 1'b0;
            ready_q       <= 1'b0;
            write_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            lane_q        <= lane_d;
            asm_q         <= asm_d;
            addr_q        <= addr_d;
            count_q       <= count_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            last_q        <= last_d;
            ready_q       <= ready_d;
            write_q       <= write_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.byte_ready_o  = ready_q;
    assign bus.mem_write_o   = write_q;
    assign bus.mem_address_o = mem_address_q;
    assign bus.mem_data_o    = mem_data_q;
    assign bus.word_count_o  = count_q;
    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
    assign state_o           = state_q;
endmodule
